// File: rtl/reg_initiator_pkg.sv
// rtl/reg_initiator_pkg.sv - shared types and defaults for the register-port initiator
package reg_initiator_pkg;

    localparam int DEFAULT_DW = 16;
    localparam int GAP_CW     = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_ACC = 3'd1,
        ST_RD_ACC = 3'd2,
        ST_RESP   = 3'd3,
        ST_GAP    = 3'd4
    } state_e;

endpackage

// File: rtl/reg_initiator.sv
// rtl/reg_initiator.sv - single-beat read/write initiator for the sel/wr/wdata register port
// Optional write verify read-back: define REG_INITIATOR_VERIFY_EN.
module reg_initiator
    import reg_initiator_pkg::*;
#(
    parameter int DW  = DEFAULT_DW,
    parameter int GAP = 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_wr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_wr,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          sel,
    output logic          wr,
    output logic [DW-1:0] wdata,
    input  logic [DW-1:0] rdata
);

    state_e              state_q, state_d;
    logic [GAP_CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]       data_q, data_d;
    logic                rsp_wr_q, rsp_wr_d;
    logic [DW-1:0]       rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                sel_q, sel_d;
    logic                wr_q, wr_d;
    logic [DW-1:0]       wdata_q, wdata_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        rsp_wr_d    = rsp_wr_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    data_d      = cmd_wr ? cmd_wdata : '0;
                    rsp_wr_d    = cmd_wr;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    state_d     = cmd_wr ? ST_WR_ACC : ST_RD_ACC;
                end
            end
            ST_WR_ACC: begin
`ifdef REG_INITIATOR_VERIFY_EN
                state_d = ST_RD_ACC;
`else
                state_d = ST_RESP;
`endif
            end
            ST_RD_ACC: begin
                rsp_rdata_d = rdata;
`ifdef REG_INITIATOR_VERIFY_EN
                // Only a write's read-back can mismatch; plain reads never flag.
                rsp_err_d   = rsp_wr_q && (rdata != data_q);
`endif
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    if (GAP > 0) begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_CW'(GAP - 1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered versions of what the next state will drive.
        cmd_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        sel_d       = (state_d == ST_WR_ACC) || (state_d == ST_RD_ACC);
        wr_d        = (state_d == ST_WR_ACC);
        wdata_d     = (state_d == ST_WR_ACC) ? data_d : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            rsp_wr_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            sel_q       <= 1'b0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            rsp_wr_q    <= rsp_wr_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            sel_q       <= sel_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_wr    = rsp_wr_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign sel       = sel_q;
    assign wr        = wr_q;
    assign wdata     = wdata_q;

endmodule

// File: tb/tb_reg_initiator.sv
// tb/tb_reg_initiator.sv - randomized check of reg_initiator against a register-level model
module tb_reg_initiator;

    localparam int DW     = 16;
    localparam int TB_GAP = 3;
`ifdef REG_INITIATOR_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_wr = 1'b0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_wr;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          sel;
    logic          wr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;

    // Responder: one register with optional write protect, combinational read.
    logic [DW-1:0] resp_reg = '0;
    logic          wp = 1'b0;
    assign rdata = (sel && !wr) ? resp_reg : 16'hDEAD;
    always @(posedge clk) begin
        if (sel && wr && !wp) resp_reg <= wdata;
    end

    reg_initiator #(.DW(DW), .GAP(TB_GAP)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .sel(sel), .wr(wr), .wdata(wdata), .rdata(rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] model_mem = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected cycles from response handshake to first sample showing cmd_ready=1.
    function automatic int exp_ready_cnt();
        return (TB_GAP > 0) ? TB_GAP + 1 : 1;
    endfunction

    task automatic wait_ready();
        int k = 0;
        while (cmd_ready !== 1'b1 && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
    endtask

    task automatic do_cmd(input bit w, input logic [DW-1:0] d, input int hold);
        logic [DW-1:0] exp_rdata;
        bit            exp_err;
        int            lat;
        int            cnt;
        logic [DW-1:0] readback;

        if (w) begin
            if (!wp) model_mem = d;
            readback  = model_mem;
            exp_rdata = VERIFY ? readback : '0;
            exp_err   = VERIFY && (readback != d);
            lat       = VERIFY ? 2 : 1;
        end else begin
            exp_rdata = model_mem;
            exp_err   = 1'b0;
            lat       = 1;
        end

        wait_ready();
        cmd_valid = 1'b1;
        cmd_wr    = w;
        cmd_wdata = d;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_wdata = $urandom;
        chk("acc_sel", sel, 1);
        chk("acc_wr", wr, w);
        chk("acc_wdata", wdata, w ? d : '0);
        chk("acc_cmd_ready", cmd_ready, 0);
        chk("acc_rsp_valid", rsp_valid, 0);
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            chk("vfy_sel", sel, 1);
            chk("vfy_wr", wr, 0);
            chk("vfy_wdata", wdata, 0);
            chk("vfy_rsp_valid", rsp_valid, 0);
        end
        @(negedge clk);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_sel", sel, 0);
        chk("rsp_wr_strobe", wr, 0);
        chk("rsp_wdata_bus", wdata, 0);
        chk("rsp_wr", rsp_wr, w);
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_err", rsp_err, exp_err);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_rdata", rsp_rdata, exp_rdata);
            chk("hold_rsp_wr", rsp_wr, w);
            chk("hold_err", rsp_err, exp_err);
            chk("hold_sel", sel, 0);
            chk("hold_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_rsp_valid", rsp_valid, 0);
        cnt = 1;
        while (cmd_ready !== 1'b1 && cnt < 30) begin
            chk("gap_sel", sel, 0);
            @(negedge clk);
            cnt++;
        end
        chk("gap_len", cnt, exp_ready_cnt());
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_wr", rsp_wr, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_sel", sel, 0);
        chk("rst_wr", wr, 0);
        chk("rst_wdata", wdata, 0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rel_cmd_ready_low", cmd_ready, 0);
        @(negedge clk);
        chk("rel_cmd_ready_high", cmd_ready, 1);
        chk("rel_sel", sel, 0);

        do_cmd(1'b1, 16'hA5A5, 0);
        do_cmd(1'b1, 16'h1234, 1);
        do_cmd(1'b0, 16'h0000, 5);

        do_cmd(1'b1, 16'h0000, 0);
        wp = 1'b1;
        do_cmd(1'b1, 16'hBEEF, 2);
        do_cmd(1'b0, 16'h0000, 0);
        wp = 1'b0;
        do_cmd(1'b1, 16'hBEEF, 0);
        do_cmd(1'b0, 16'h0000, 0);

        // Reset asserted while the write access is on the bus.
        wait_ready();
        cmd_valid = 1'b1;
        cmd_wr    = 1'b1;
        cmd_wdata = 16'h5A5A;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mid_sel_before", sel, 1);
        rstn = 1'b0;
        #1;
        chk("mid_sel_drop", sel, 0);
        chk("mid_wr_drop", wr, 0);
        chk("mid_wdata_drop", wdata, 0);
        @(negedge clk);
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_cmd_ready", cmd_ready, 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("mid_rel_ready", cmd_ready, 1);
        chk("mid_rel_rsp_valid", rsp_valid, 0);
        do_cmd(1'b0, 16'h0000, 0);

        for (int n = 0; n < 24; n++) begin
            wp = ($urandom_range(0, 4) == 0);
            do_cmd(1'($urandom_range(0, 1)), DW'($urandom), $urandom_range(0, 3));
        end
        wp = 1'b0;
        do_cmd(1'b0, 16'h0000, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
